// File: rtl/mochila_xbar_pkg.sv
// Shared types and helpers for the mochila OBI crossbar: bus structs,
// address rules and index-width helpers.
package mochila_xbar_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } addr_rule_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hBADC_AB1E;

  // Width of an index into n items; never zero so one-entry cases still get a bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic logic rule_hit(input addr_rule_t rule, input logic [31:0] addr);
    return (addr & rule.mask) == rule.base;
  endfunction

endpackage

// File: rtl/mochila_rr_arbiter.sv
// Round-robin arbiter with a sticky selection: once a requester is shown and
// not yet acknowledged it stays selected while it keeps requesting.
module mochila_rr_arbiter
  import mochila_xbar_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N-1:0]             req_i,
  input  logic                     ack_i,
  output logic [N-1:0]             gnt_o,
  output logic [idx_width(N)-1:0]  idx_o,
  output logic                     valid_o
);

  localparam int unsigned IW = idx_width(N);

  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] lock_idx_reg, lock_idx_next;
  logic          lock_reg, lock_next;

  // Descending scans leave the lowest matching index; the second scan
  // overrides with the lowest requester at or above the pointer.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    if (lock_reg && req_i[lock_idx_reg]) begin
      idx_o   = lock_idx_reg;
      valid_o = 1'b1;
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          idx_o   = IW'(i);
          valid_o = 1'b1;
        end
      end
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i] && (IW'(i) >= ptr_reg)) begin
          idx_o   = IW'(i);
          valid_o = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt_o[gi] = valid_o && (idx_o == IW'(gi));
  end

  always_comb begin
    ptr_next      = ptr_reg;
    lock_next     = valid_o && !ack_i;
    lock_idx_next = idx_o;
    if (ack_i) begin
      ptr_next = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_reg      <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      lock_reg     <= lock_next;
      lock_idx_reg <= lock_idx_next;
    end
  end

endmodule

// File: rtl/mochila_obi_xbar.sv
// N-master to N-slave OBI crossbar with per-target round-robin arbitration,
// in-order response routing through per-target ID FIFOs and a built-in error target.
module mochila_obi_xbar
  import mochila_xbar_pkg::*;
#(
  parameter int unsigned                N_MASTERS       = 3,
  parameter int unsigned                N_SLAVES        = 3,
  parameter int unsigned                MAX_OUTSTANDING = 2,
  parameter logic [N_SLAVES-1:0][31:0]  SLAVE_BASE      = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES-1:0][31:0]  SLAVE_MASK      = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter logic [31:0]                ERR_RDATA       = DEFAULT_ERR_RDATA
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [N_MASTERS],
  output obi_resp_t master_resp_o [N_MASTERS],
  output obi_req_t  slave_req_o   [N_SLAVES],
  input  obi_resp_t slave_resp_i  [N_SLAVES]
);

  localparam int unsigned NT      = N_SLAVES + 1;
  localparam int unsigned MW      = idx_width(N_MASTERS);
  localparam int unsigned TW      = idx_width(NT);
  localparam int unsigned PW      = idx_width(MAX_OUTSTANDING);
  localparam int unsigned FCW     = cnt_width(MAX_OUTSTANDING);
  localparam int unsigned CNT_MAX = N_SLAVES * MAX_OUTSTANDING;
  localparam int unsigned OCW     = cnt_width(CNT_MAX);
  localparam logic [TW-1:0] ERR_TGT = TW'(N_SLAVES);

  addr_rule_t           rules [N_SLAVES];
  logic [TW-1:0]        dec_tgt [N_MASTERS];
  logic [N_MASTERS-1:0] blocked;

  logic [N_MASTERS-1:0] arb_req [NT];
  logic [N_MASTERS-1:0] arb_gnt [NT];
  logic [MW-1:0]        arb_idx [NT];
  logic [MW-1:0]        fifo_head [NT];
  logic [31:0]          tgt_rdata [NT];
  logic [NT-1:0]        arb_valid, tgt_gnt, tgt_rvalid, can_push, fwd_req, hs, pop, fifo_empty;
  logic                 err_rvalid_reg;

  logic [OCW-1:0]       out_cnt_reg [N_MASTERS];
  logic [TW-1:0]        last_tgt_reg [N_MASTERS];
  logic [N_MASTERS-1:0] m_gnt, m_rvalid;
  logic [31:0]          m_rdata [N_MASTERS];

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_rule
    assign rules[gi] = '{base: SLAVE_BASE[gi], mask: SLAVE_MASK[gi]};
  end

  // Lowest-index region wins; a master with responses pending elsewhere is held back.
  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) begin
      dec_tgt[m] = ERR_TGT;
      for (int s = N_SLAVES - 1; s >= 0; s--) begin
        if (rule_hit(rules[s], master_req_i[m].addr)) begin
          dec_tgt[m] = TW'(s);
        end
      end
      blocked[m] = (out_cnt_reg[m] != '0) && (dec_tgt[m] != last_tgt_reg[m]);
    end
  end

  always_comb begin
    for (int t = 0; t < NT; t++) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        arb_req[t][m] = master_req_i[m].req && (dec_tgt[m] == TW'(t)) && !blocked[m];
      end
    end
  end

  for (genvar gi = 0; gi < NT; gi++) begin : g_tgt
    logic [MW-1:0]  mem_reg [MAX_OUTSTANDING];
    logic [PW-1:0]  wptr_reg, rptr_reg;
    logic [FCW-1:0] cnt_reg;
    logic           synced_reg;

    mochila_rr_arbiter #(.N(N_MASTERS)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (arb_req[gi]),
      .ack_i   (hs[gi]),
      .gnt_o   (arb_gnt[gi]),
      .idx_o   (arb_idx[gi]),
      .valid_o (arb_valid[gi])
    );

    assign fifo_empty[gi] = (cnt_reg == '0);
    assign fifo_head[gi]  = mem_reg[rptr_reg];
    assign pop[gi]        = tgt_rvalid[gi] && !fifo_empty[gi];
    // A response leaving this cycle frees a slot, so a full FIFO can still accept.
    assign can_push[gi]   = (cnt_reg != FCW'(MAX_OUTSTANDING)) || pop[gi];
    assign fwd_req[gi]    = arb_valid[gi] && can_push[gi];
    assign hs[gi]         = fwd_req[gi] && tgt_gnt[gi];

    always_ff @(posedge clk_i) begin
      if (hs[gi]) begin
        mem_reg[wptr_reg] <= arb_idx[gi];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wptr_reg   <= '0;
        rptr_reg   <= '0;
        cnt_reg    <= '0;
        synced_reg <= 1'b0;
      end else begin
        if (hs[gi]) begin
          wptr_reg   <= (wptr_reg == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_reg + 1'b1;
          synced_reg <= 1'b1;
        end
        if (pop[gi]) begin
          rptr_reg <= (rptr_reg == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_reg + 1'b1;
        end
        if (hs[gi] && !pop[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (!hs[gi] && pop[gi]) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end

    if (gi < N_SLAVES) begin : g_slave
      assign tgt_gnt[gi]     = slave_resp_i[gi].gnt;
      assign tgt_rvalid[gi]  = slave_resp_i[gi].rvalid;
      assign tgt_rdata[gi]   = slave_resp_i[gi].rdata;
      assign slave_req_o[gi] = (!rst_i && fwd_req[gi]) ? master_req_i[arb_idx[gi]] : '0;

      // Stray responses are expected only while draining traffic that a reset orphaned.
      a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
        !(synced_reg && slave_resp_i[gi].rvalid && fifo_empty[gi]));
    end else begin : g_err
      assign tgt_gnt[gi]    = 1'b1;
      assign tgt_rvalid[gi] = err_rvalid_reg;
      assign tgt_rdata[gi]  = ERR_RDATA;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          err_rvalid_reg <= 1'b0;
        end else begin
          err_rvalid_reg <= hs[gi];
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < N_MASTERS; m++) begin
      m_gnt[m]    = 1'b0;
      m_rvalid[m] = 1'b0;
      m_rdata[m]  = '0;
    end
    for (int t = 0; t < NT; t++) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        if (hs[t] && arb_gnt[t][m]) begin
          m_gnt[m] = 1'b1;
        end
        if (pop[t] && (fifo_head[t] == MW'(m))) begin
          m_rvalid[m] = 1'b1;
          m_rdata[m]  = tgt_rdata[t];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_mresp
    assign master_resp_o[gi] = rst_i ? '0 : {m_gnt[gi], m_rvalid[gi], m_rdata[gi]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        out_cnt_reg[m]  <= '0;
        last_tgt_reg[m] <= '0;
      end
    end else begin
      for (int m = 0; m < N_MASTERS; m++) begin
        if (m_gnt[m]) begin
          last_tgt_reg[m] <= dec_tgt[m];
        end
        if (m_gnt[m] && !m_rvalid[m] && (out_cnt_reg[m] != OCW'(CNT_MAX))) begin
          out_cnt_reg[m] <= out_cnt_reg[m] + 1'b1;
        end else if (!m_gnt[m] && m_rvalid[m] && (out_cnt_reg[m] != '0)) begin
          out_cnt_reg[m] <= out_cnt_reg[m] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mochila_obi_xbar.sv
// Directed bench for mochila_obi_xbar: routing, round-robin order, FIFO
// back-pressure, ordering block, error target and mid-transaction reset.
module tb_mochila_obi_xbar;
  import mochila_xbar_pkg::*;

  localparam int unsigned NM = 3;
  localparam int unsigned NS = 3;

  logic      clk = 1'b0;
  logic      rst;
  obi_req_t  mreq  [NM];
  obi_resp_t mresp [NM];
  obi_req_t  sreq  [NS];
  obi_resp_t sresp [NS];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mochila_obi_xbar dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .master_req_i  (mreq),
    .master_resp_o (mresp),
    .slave_req_o   (sreq),
    .slave_resp_i  (sresp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %s = 0x%08h", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NM; i++) mreq[i] = '0;
    for (int s = 0; s < NS; s++) sresp[s] = '0;
  endtask

  task automatic mrd(input int m, input logic [31:0] a, input logic we);
    mreq[m] = '{req: 1'b1, we: we, be: 4'hF, addr: a, wdata: 32'hCAFE_0000};
  endtask

  task automatic sset(input int s, input logic g, input logic v, input logic [31:0] d);
    sresp[s] = '{gnt: g, rvalid: v, rdata: d};
  endtask

  function automatic logic [31:0] gnts();
    return {29'd0, mresp[2].gnt, mresp[1].gnt, mresp[0].gnt};
  endfunction

  function automatic logic [31:0] rvs();
    return {29'd0, mresp[2].rvalid, mresp[1].rvalid, mresp[0].rvalid};
  endfunction

  function automatic logic [31:0] sreqs();
    return {29'd0, sreq[2].req, sreq[1].req, sreq[0].req};
  endfunction

  logic [2:0] t2_g  [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
  logic [2:0] t2_rv [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [2:0] t3_m  [7] = '{3'b111, 3'b110, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
  logic [2:0] t3_g  [7] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
  logic [2:0] t3_rv [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100};
  logic [31:0] t3_addr [3] = '{32'h2000_0000, 32'h2100_0000, 32'h2F00_0000};

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    // Outputs must stay quiet in reset even with a live request.
    mrd(0, 32'h1000_0000, 1'b0);
    sset(1, 1'b1, 1'b0, 32'h0);
    #1;
    check("rst_gnt", gnts(), 32'd0);
    check("rst_sreq", sreqs(), 32'd0);
    check("rst_rv", rvs(), 32'd0);
    tick();
    idle();
    rst = 1'b0;

    // Single read to slave 1, response two cycles after grant.
    tick();
    sset(1, 1'b1, 1'b0, 32'h0);
    mrd(0, 32'h1000_0010, 1'b0);
    #1;
    check("t1_sreq", sreqs(), 32'b010);
    check("t1_saddr", sreq[1].addr, 32'h1000_0010);
    check("t1_gnt", gnts(), 32'b001);
    tick();
    idle();
    #1;
    check("t1_gnt_off", gnts(), 32'd0);
    tick();
    sset(1, 1'b0, 1'b1, 32'h1234_5678);
    #1;
    check("t1_rv", rvs(), 32'b001);
    check("t1_rdata0", mresp[0].rdata, 32'h1234_5678);
    check("t1_rdata1", mresp[1].rdata, 32'h0);
    check("t1_rdata2", mresp[2].rdata, 32'h0);
    tick();
    idle();

    // Three masters contend for slave 0; responses return one cycle after each grant.
    for (int k = 0; k < 5; k++) begin
      tick();
      idle();
      if (k < 4) begin
        mrd(0, 32'h0000_0000, 1'b0);
        mrd(1, 32'h0000_0004, 1'b0);
        mrd(2, 32'h0000_0008, 1'b0);
      end
      sset(0, 1'b1, k >= 1, 32'hA0 + k);
      #1;
      check($sformatf("t2_gnt_c%0d", k), gnts(), {29'd0, t2_g[k]});
      check($sformatf("t2_rv_c%0d", k), rvs(), {29'd0, t2_rv[k]});
    end
    tick();
    idle();

    // Slave 2 grants without responding: the third request waits for a free slot.
    for (int k = 0; k < 7; k++) begin
      tick();
      idle();
      for (int m = 0; m < NM; m++) begin
        if (t3_m[k][m]) mrd(m, t3_addr[m], 1'b0);
      end
      sset(2, 1'b1, k >= 4, 32'hB0 + k);
      #1;
      check($sformatf("t3_gnt_c%0d", k), gnts(), {29'd0, t3_g[k]});
      check($sformatf("t3_sreq2_c%0d", k), {31'd0, sreq[2].req}, {31'd0, t3_g[k] != 3'b000});
      check($sformatf("t3_rv_c%0d", k), rvs(), {29'd0, t3_rv[k]});
    end
    tick();
    idle();

    // Master 0 switches targets with a response still pending on slave 0.
    tick();
    sset(0, 1'b1, 1'b0, 32'h0);
    sset(1, 1'b1, 1'b0, 32'h0);
    mrd(0, 32'h0000_0100, 1'b0);
    #1;
    check("t4_first_gnt", gnts(), 32'b001);
    for (int k = 0; k < 3; k++) begin
      tick();
      mrd(0, 32'h1000_0020, 1'b0);
      sset(0, 1'b1, k == 2, 32'hC0C0_0000);
      #1;
      check($sformatf("t4_blk_gnt_c%0d", k), gnts(), 32'd0);
      check($sformatf("t4_blk_sreq_c%0d", k), sreqs(), 32'd0);
    end
    check("t4_rv0", rvs(), 32'b001);
    check("t4_rdata0", mresp[0].rdata, 32'hC0C0_0000);
    tick();
    sset(0, 1'b1, 1'b0, 32'h0);
    #1;
    check("t4_unblk_sreq", sreqs(), 32'b010);
    check("t4_unblk_gnt", gnts(), 32'b001);
    tick();
    idle();
    sset(1, 1'b0, 1'b1, 32'h0000_D00D);
    #1;
    check("t4_rv1", rvs(), 32'b001);
    check("t4_rdata1", mresp[0].rdata, 32'h0000_D00D);
    tick();
    idle();

    // Unmapped read then write back to back from master 1.
    tick();
    mrd(1, 32'hF000_0000, 1'b0);
    #1;
    check("t5_gnt0", gnts(), 32'b010);
    check("t5_sreq0", sreqs(), 32'd0);
    check("t5_rv0", rvs(), 32'd0);
    tick();
    mrd(1, 32'hF000_0004, 1'b1);
    #1;
    check("t5_gnt1", gnts(), 32'b010);
    check("t5_rv1", rvs(), 32'b010);
    check("t5_rdata1", mresp[1].rdata, 32'hBADC_AB1E);
    tick();
    idle();
    #1;
    check("t5_gnt2", gnts(), 32'd0);
    check("t5_rv2", rvs(), 32'b010);
    check("t5_rdata2", mresp[1].rdata, 32'hBADC_AB1E);
    tick();
    #1;
    check("t5_rv3", rvs(), 32'd0);

    // Two reads in flight on slave 0, then reset; late responses must vanish.
    tick();
    sset(0, 1'b1, 1'b0, 32'h0);
    mrd(0, 32'h0000_0000, 1'b0);
    #1;
    check("t6_gnt0", gnts(), 32'b001);
    tick();
    mrd(0, 32'h0000_0004, 1'b0);
    #1;
    check("t6_gnt1", gnts(), 32'b001);
    tick();
    rst = 1'b1;
    mrd(2, 32'h0000_0008, 1'b0);
    #1;
    check("t6_rst_gnt", gnts(), 32'd0);
    check("t6_rst_sreq", sreqs(), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      sset(0, 1'b0, 1'b1, 32'h5555_AAAA);
      #1;
      check($sformatf("t6_late_rv_c%0d", k), rvs(), 32'd0);
      check($sformatf("t6_late_rdata_c%0d", k), mresp[0].rdata, 32'h0);
      tick();
    end
    idle();
    sset(1, 1'b1, 1'b0, 32'h0);
    mrd(0, 32'h1000_0000, 1'b0);
    #1;
    check("t6_after_sreq", sreqs(), 32'b010);
    check("t6_after_gnt", gnts(), 32'b001);
    tick();
    idle();
    sset(1, 1'b0, 1'b1, 32'h7777_0001);
    #1;
    check("t6_after_rv", rvs(), 32'b001);
    check("t6_after_rdata", mresp[0].rdata, 32'h7777_0001);
    tick();
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mochila_obi_xbar.md
# mochila_obi_xbar

Parametrised OBI crossbar for the mochila subsystem: connects N_MASTERS OBI masters (core instr, core data, external master, future accelerators) to N_SLAVES OBI slaves (RAM banks, peripheral system, external slave) through per-slave round-robin arbitration. It tracks outstanding transactions per slave so responses are routed back to the issuing master in order, and supports up to MAX_OUTSTANDING pipelined transactions per slave. Unmapped addresses are answered by a built-in error responder. It is the successor to the fixed-topology bus system.

## Interface
- N_MASTERS, 3: number of master ports (1..8).
- N_SLAVES, 3: number of mapped slave ports (1..8).
- MAX_OUTSTANDING, 2: per-slave in-flight transaction depth (power of two, 1..8).
- SLAVE_BASE, array [N_SLAVES] of 32-bit: region base address per slave.
- SLAVE_MASK, array [N_SLAVES] of 32-bit: region mask; hit when (addr & MASK) == BASE.
- ERR_RDATA, 32'hBADC_AB1E: read data returned for unmapped accesses.
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- master_req_i  in  obi_req_t [N_MASTERS]  master requests (req, we, be, addr, wdata).
- master_resp_o  out  obi_resp_t [N_MASTERS]  master responses (gnt, rvalid, rdata).
- slave_req_o  out  obi_req_t [N_SLAVES]  slave requests.
- slave_resp_i  in  obi_resp_t [N_SLAVES]  slave responses.

## Operation
- Decode: each master's addr compared against all regions; lowest-index hit wins; no hit selects error target (index N_SLAVES).
- Per-target arbiter: among masters with req=1 decoded to that target and not blocked, grant round-robin. Pointer starts at master 0 after reset; on accepted handshake (slave gnt), pointer moves to granted index + 1 (mod N_MASTERS). No handshake: pointer holds.
- Forwarding: slave_req_o[s] = selected master's request fields, req=1 only if ID FIFO for s not full. master_resp_o[m].gnt = slave_resp_i[s].gnt when m selected on s. Combinational path req->gnt, no added latency.
- ID FIFO per target, depth MAX_OUTSTANDING, stores granted master index. Push on gnt handshake; pop on slave rvalid. Push and pop same cycle when full: allowed, count unchanged.
- Response routing: slave_resp_i[s].rvalid/rdata forwarded to master at FIFO head; other masters see rvalid=0, rdata=0.
- Ordering rule per master: outstanding counter and last-target register. Master blocked from arbitration if counter>0 and decoded target != last target. Counter saturates at N_SLAVES*MAX_OUTSTANDING (never reached by construction).
- Error responder: grants immediately when selected; rvalid one cycle after gnt with rdata=ERR_RDATA; writes discarded. Uses same FIFO/arbiter path.
- rvalid from a slave with empty FIFO: ignored (flagged by assertion).

## Timing
- Reset: all master_resp_o and slave_req_o fields 0; FIFOs empty; counters 0; RR pointers 0.
- Request to gnt: 0 cycles added. rvalid to master: 0 cycles added (combinational from slave).
- Error target: gnt cycle N, rvalid cycle N+1; back-to-back one per cycle.
- Reset mid-transaction: all tracking cleared; late rvalids afterwards ignored.
- Master must hold request stable until gnt (OBI rule); crossbar may change selection only after a handshake or when selected master drops req.

## Structure
- Shared package mochila_xbar_pkg: address-rule typedef (base, mask), default ERR_RDATA, index-width functions ($clog2 wrappers).
- Sub-module mochila_rr_arbiter (N requests, one-hot grant, pointer update on ack_i); instantiated N_SLAVES+1 times. ID FIFO inline.

## Test plan
- Single master 0 reads slave 1 (addr inside region 1), slave rvalid 2 cycles later with 0x1234_5678 -> only master 0 sees rvalid with 0x1234_5678.
- Masters 0,1,2 hold req to slave 0, slave always gnt -> grants order 0,1,2,0 over four cycles.
- MAX_OUTSTANDING=2, slave gnts 3 requests without rvalid -> third req held low on slave_req_o until first rvalid.
- Master 0 issues to slave 0 (pending), then addr in slave 1 -> blocked until slave 0 rvalid, then granted.
- Access to unmapped addr 0xF000_0000 -> gnt same cycle, rvalid next cycle, rdata 0xBADC_AB1E.
- Assert rst_i with 2 transactions in flight -> all outputs 0 next cycle, following rvalid not forwarded.
